// File: rtl/pipe_pkg.sv
// Shared definitions for the MIPS ID stage: encodings, ALU/pc_sel codes,
// the decoded-control bundle and the instruction decoder.
package pipe_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_SLT = 4'd4,
        ALU_SLL = 4'd5,
        ALU_LUI = 4'd6
    } alu_op_e;

    typedef enum logic [1:0] {
        SEL_NPC = 2'd0,
        SEL_BR  = 2'd1,
        SEL_JMP = 2'd2
    } pc_sel_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] instr;
    } ifid_t;

    localparam ifid_t IFID_NOP = '{pc: 32'h0, npc: 32'h0, instr: NOP_INSTR};

    typedef struct packed {
        logic        rs_used;
        logic        rt_used;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        alu_src_imm;
        logic        link;
        logic        branch_eq;
        logic        branch_ne;
        logic        jump;
        logic        jump_reg;
        alu_op_e     alu_op;
        logic [4:0]  dest;
        logic [31:0] imm;
    } ctrl_t;

    function automatic logic raw_hit(input logic [4:0] src,
                                     input logic [4:0] ex_rd, input logic ex_we,
                                     input logic [4:0] mem_rd, input logic mem_we);
        return (src != 5'd0) && ((ex_we && src == ex_rd) || (mem_we && src == mem_rd));
    endfunction

    function automatic ctrl_t decode(input logic [31:0] instr);
        ctrl_t       c;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [15:0] imm16;
        rt    = instr[20:16];
        rd    = instr[15:11];
        imm16 = instr[15:0];
        // NOTE: every field gets a default before the case so no path leaves one unassigned (no latches).
        c        = '0;
        c.alu_op = ALU_SLL;
        c.imm    = {{16{imm16[15]}}, imm16};
        case (instr[31:26])
            OP_RTYPE: begin
                case (instr[5:0])
                    FN_ADDU, FN_SUBU, FN_AND, FN_OR, FN_SLT: begin
                        c.rs_used   = 1'b1;
                        c.rt_used   = 1'b1;
                        c.reg_write = 1'b1;
                        c.dest      = rd;
                        case (instr[5:0])
                            FN_SUBU: c.alu_op = ALU_SUB;
                            FN_AND:  c.alu_op = ALU_AND;
                            FN_OR:   c.alu_op = ALU_OR;
                            FN_SLT:  c.alu_op = ALU_SLT;
                            default: c.alu_op = ALU_ADD;
                        endcase
                    end
                    FN_SLL: begin
                        c.rt_used   = 1'b1;
                        c.reg_write = 1'b1;
                        c.dest      = rd;
                    end
                    FN_JR: begin
                        c.rs_used  = 1'b1;
                        c.jump_reg = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_ADDIU, OP_ANDI, OP_ORI, OP_LW: begin
                c.rs_used     = 1'b1;
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
                c.dest        = rt;
                c.mem_read    = (instr[31:26] == OP_LW);
                case (instr[31:26])
                    OP_ANDI: begin c.alu_op = ALU_AND; c.imm = {16'h0, imm16}; end
                    OP_ORI:  begin c.alu_op = ALU_OR;  c.imm = {16'h0, imm16}; end
                    default: c.alu_op = ALU_ADD;
                endcase
            end
            OP_LUI: begin
                c.reg_write   = 1'b1;
                c.alu_src_imm = 1'b1;
                c.dest        = rt;
                c.alu_op      = ALU_LUI;
                c.imm         = {imm16, 16'h0};
            end
            OP_SW: begin
                c.rs_used     = 1'b1;
                c.rt_used     = 1'b1;
                c.mem_write   = 1'b1;
                c.alu_src_imm = 1'b1;
                c.alu_op      = ALU_ADD;
            end
            OP_BEQ, OP_BNE: begin
                c.rs_used   = 1'b1;
                c.rt_used   = 1'b1;
                c.branch_eq = (instr[31:26] == OP_BEQ);
                c.branch_ne = (instr[31:26] == OP_BNE);
                c.alu_op    = ALU_SUB;
            end
            OP_J: c.jump = 1'b1;
            OP_JAL: begin
                c.jump      = 1'b1;
                c.link      = 1'b1;
                c.reg_write = 1'b1;
                c.dest      = 5'd31;
                c.alu_op    = ALU_ADD;
            end
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/pipe_id_if.sv
// Fetch/EX/MEM/WB-facing signal bundle of the ID stage.
interface pipe_id_if;
    logic [31:0] in_pc;
    logic [31:0] in_npc;
    logic [31:0] in_instruction;
    logic [4:0]  in_ex_rd;
    logic        in_ex_reg_write;
    logic [4:0]  in_mem_rd;
    logic        in_mem_reg_write;
    logic [4:0]  in_wb_rd;
    logic [31:0] in_wb_data;
    logic        in_wb_reg_write;

    logic        out_stall;
    logic [1:0]  out_pc_sel;
    logic [31:0] out_pc_baddr;
    logic [31:0] out_pc_jaddr;
    logic [31:0] out_npc;
    logic [31:0] out_rs_val;
    logic [31:0] out_rt_val;
    logic [31:0] out_imm;
    logic [4:0]  out_shamt;
    logic [4:0]  out_dest;
    logic [3:0]  out_alu_op;
    logic        out_alu_src_imm;
    logic        out_mem_read;
    logic        out_mem_write;
    logic        out_reg_write;
    logic        out_link;

    modport slave (
        input  in_pc, in_npc, in_instruction, in_ex_rd, in_ex_reg_write,
               in_mem_rd, in_mem_reg_write, in_wb_rd, in_wb_data, in_wb_reg_write,
        output out_stall, out_pc_sel, out_pc_baddr, out_pc_jaddr, out_npc,
               out_rs_val, out_rt_val, out_imm, out_shamt, out_dest, out_alu_op,
               out_alu_src_imm, out_mem_read, out_mem_write, out_reg_write, out_link
    );

    modport master (
        output in_pc, in_npc, in_instruction, in_ex_rd, in_ex_reg_write,
               in_mem_rd, in_mem_reg_write, in_wb_rd, in_wb_data, in_wb_reg_write,
        input  out_stall, out_pc_sel, out_pc_baddr, out_pc_jaddr, out_npc,
               out_rs_val, out_rt_val, out_imm, out_shamt, out_dest, out_alu_op,
               out_alu_src_imm, out_mem_read, out_mem_write, out_reg_write, out_link
    );
endinterface

// File: rtl/regfile.sv
// 32x32 register file: two combinational read ports with write-first bypass,
// one write port, $0 hardwired to zero, synchronous active-low clear.
module regfile (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra1,
    input  logic [4:0]  ra2,
    output logic [31:0] rd1,
    output logic [31:0] rd2,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd
);
    logic [31:0] mem [0:31];
    logic        wr_en;

    assign wr_en = we && rst_n && (wa != 5'd0);

    // NOTE: the whole array is cleared on reset, so this maps to flops rather than a RAM macro.
    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[wa] <= wd;
        end
    end

    assign rd1 = (ra1 == 5'd0) ? 32'h0 : (wr_en && wa == ra1) ? wd : mem[ra1];
    assign rd2 = (ra2 == 5'd0) ? 32'h0 : (wr_en && wa == ra2) ? wd : mem[ra2];
endmodule

// File: rtl/pipe_id.sv
// MIPS instruction-decode stage: IF/ID latch, register file, decode,
// RAW-stall detection and branch/jump resolution fed back to fetch.
module pipe_id
    import pipe_pkg::*;
(
    input  logic      in_clk,
    input  logic      in_rst,
    pipe_id_if.slave  bus
);
    ifid_t       ifid;
    ctrl_t       ctrl;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        stall;
    pc_sel_e     pc_sel;

    assign rs   = ifid.instr[25:21];
    assign rt   = ifid.instr[20:16];
    assign ctrl = decode(ifid.instr);

    regfile u_regfile (
        .clk   (in_clk),
        .rst_n (in_rst),
        .ra1   (rs),
        .ra2   (rt),
        .rd1   (rs_val),
        .rd2   (rt_val),
        .we    (bus.in_wb_reg_write),
        .wa    (bus.in_wb_rd),
        .wd    (bus.in_wb_data)
    );

    // WB needs no check here: the regfile bypass already delivers its value.
    assign stall =
        (ctrl.rs_used && raw_hit(rs, bus.in_ex_rd, bus.in_ex_reg_write,
                                 bus.in_mem_rd, bus.in_mem_reg_write)) ||
        (ctrl.rt_used && raw_hit(rt, bus.in_ex_rd, bus.in_ex_reg_write,
                                 bus.in_mem_rd, bus.in_mem_reg_write));

    always_comb begin
        pc_sel = SEL_NPC;
        if (!stall) begin
            if ((ctrl.branch_eq && rs_val == rt_val) || (ctrl.branch_ne && rs_val != rt_val))
                pc_sel = SEL_BR;
            else if (ctrl.jump || ctrl.jump_reg)
                pc_sel = SEL_JMP;
        end
    end

    // A redirect squashes the wrong-path instruction fetch is presenting.
    always_ff @(posedge in_clk) begin
        if (!in_rst)
            ifid <= IFID_NOP;
        else if (pc_sel != SEL_NPC)
            ifid <= IFID_NOP;
        else if (!stall)
            ifid <= '{pc: bus.in_pc, npc: bus.in_npc, instr: bus.in_instruction};
    end

    assign bus.out_stall    = stall;
    assign bus.out_pc_sel   = pc_sel;
    assign bus.out_pc_baddr = (ctrl.branch_eq || ctrl.branch_ne)
                            ? ifid.pc + 32'd4 + {ctrl.imm[29:0], 2'b00} : 32'h0;
    assign bus.out_pc_jaddr = ctrl.jump_reg ? rs_val
                            : ctrl.jump     ? {ifid.npc[31:28], ifid.instr[25:0], 2'b00}
                            : 32'h0;

    assign bus.out_npc         = ifid.npc;
    assign bus.out_rs_val      = rs_val;
    assign bus.out_rt_val      = rt_val;
    assign bus.out_imm         = ctrl.imm;
    assign bus.out_shamt       = ifid.instr[10:6];
    assign bus.out_dest        = ctrl.dest;
    assign bus.out_alu_op      = ctrl.alu_op;
    assign bus.out_alu_src_imm = ctrl.alu_src_imm;
    assign bus.out_mem_read    = ctrl.mem_read  && !stall;
    assign bus.out_mem_write   = ctrl.mem_write && !stall;
    assign bus.out_reg_write   = ctrl.reg_write && !stall && (ctrl.dest != 5'd0);
    assign bus.out_link        = ctrl.link      && !stall;
endmodule

// File: tb/tb_pipe_id.sv
// Directed bench for pipe_id: stimulus pushes hand-computed expectations into
// a scoreboard queue; a monitor pops and compares them mid-cycle.
module tb_pipe_id;
    import pipe_pkg::*;

    logic in_clk = 1'b0;
    logic in_rst = 1'b0;
    always #5 in_clk = ~in_clk;

    pipe_id_if bus();

    pipe_id dut (
        .in_clk (in_clk),
        .in_rst (in_rst),
        .bus    (bus)
    );

    typedef enum int {
        F_STALL, F_PC_SEL, F_BADDR, F_JADDR, F_NPC, F_RS, F_RT, F_IMM,
        F_SHAMT, F_DEST, F_ALU_OP, F_ALU_SRC, F_MEM_RD, F_MEM_WR, F_REG_WR, F_LINK
    } field_e;

    typedef struct {
        string       name;
        field_e      field;
        logic [31:0] value;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
        end
    endtask

    function automatic logic [31:0] actual(input field_e f);
        case (f)
            F_STALL:  return 32'(bus.out_stall);
            F_PC_SEL: return 32'(bus.out_pc_sel);
            F_BADDR:  return bus.out_pc_baddr;
            F_JADDR:  return bus.out_pc_jaddr;
            F_NPC:    return bus.out_npc;
            F_RS:     return bus.out_rs_val;
            F_RT:     return bus.out_rt_val;
            F_IMM:    return bus.out_imm;
            F_SHAMT:  return 32'(bus.out_shamt);
            F_DEST:   return 32'(bus.out_dest);
            F_ALU_OP: return 32'(bus.out_alu_op);
            F_ALU_SRC:return 32'(bus.out_alu_src_imm);
            F_MEM_RD: return 32'(bus.out_mem_read);
            F_MEM_WR: return 32'(bus.out_mem_write);
            F_REG_WR: return 32'(bus.out_reg_write);
            default:  return 32'(bus.out_link);
        endcase
    endfunction

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge in_clk);
            #2;
            while (sb.size() > 0) begin
                e = sb.pop_front();
                check($sformatf("%s.%s", e.name, e.field.name()), actual(e.field), e.value);
            end
        end
    end

    task automatic expect_val(input string name, input field_e f, input logic [31:0] v);
        exp_t e;
        e.name  = name;
        e.field = f;
        e.value = v;
        sb.push_back(e);
    endtask

    task automatic expect_nop(input string name);
        field_e f;
        for (int i = 0; i <= int'(F_LINK); i++) begin
            f = field_e'(i);
            expect_val(name, f, (f == F_ALU_OP) ? 32'(ALU_SLL) : 32'h0);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] fn, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [4:0] rd,
                                          input logic [4:0] sh);
        return {OP_RTYPE, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
        return {op, tgt};
    endfunction

    task automatic fetch(input logic [31:0] pc, input logic [31:0] instr);
        bus.in_pc          = pc;
        bus.in_npc         = pc + 32'd4;
        bus.in_instruction = instr;
    endtask

    task automatic hz(input logic [4:0] ex_rd, input logic ex_we,
                      input logic [4:0] mem_rd, input logic mem_we);
        bus.in_ex_rd         = ex_rd;
        bus.in_ex_reg_write  = ex_we;
        bus.in_mem_rd        = mem_rd;
        bus.in_mem_reg_write = mem_we;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] data, input logic we);
        bus.in_wb_rd        = rd;
        bus.in_wb_data      = data;
        bus.in_wb_reg_write = we;
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        in_rst = 1'b0;
        fetch(32'h0, 32'h2401_0005);
        hz(5'd0, 1'b0, 5'd0, 1'b0);
        wb(5'd0, 32'h0, 1'b0);

        tick(); expect_nop("rst1");
        tick(); expect_nop("rst2");
        in_rst = 1'b1;
        fetch(32'h100, enc_r(FN_ADDU, 5'd1, 5'd0, 5'd3, 5'd0));

        tick();  // addu $3,$1,$0
        expect_val("r1_after_rst", F_RS, 32'h0);
        expect_val("addu_dest", F_DEST, 32'd3);
        expect_val("addu_rw", F_REG_WR, 32'd1);
        expect_val("addu_npc", F_NPC, 32'h104);
        expect_val("addu_alu", F_ALU_OP, 32'(ALU_ADD));
        fetch(32'h104, enc_r(FN_ADDU, 5'd2, 5'd0, 5'd3, 5'd0));

        tick();  // addu $3,$2,$0 with same-cycle WB of $2
        wb(5'd2, 32'h1234, 1'b1);
        expect_val("wb_bypass", F_RS, 32'h1234);
        expect_val("bypass_dest", F_DEST, 32'd3);
        expect_val("bypass_rw", F_REG_WR, 32'd1);
        fetch(32'h108, enc_r(FN_ADDU, 5'd2, 5'd0, 5'd3, 5'd0));

        tick();  // same addu, EX hazard on $2
        wb(5'd0, 32'h0, 1'b0);
        hz(5'd2, 1'b1, 5'd0, 1'b0);
        expect_val("ex_stall", F_STALL, 32'd1);
        expect_val("stall_rw", F_REG_WR, 32'd0);
        expect_val("stall_sel", F_PC_SEL, 32'd0);
        expect_val("rf_stored", F_RS, 32'h1234);
        fetch(32'h10C, enc_i(OP_ORI, 5'd0, 5'd4, 16'hBEEF));

        tick();  // hazard moves to MEM
        hz(5'd0, 1'b0, 5'd2, 1'b1);
        expect_val("mem_stall", F_STALL, 32'd1);
        expect_val("held_npc", F_NPC, 32'h10C);

        tick();  // hazard gone
        hz(5'd0, 1'b0, 5'd0, 1'b0);
        expect_val("release_stall", F_STALL, 32'd0);
        expect_val("release_rw", F_REG_WR, 32'd1);
        expect_val("release_npc", F_NPC, 32'h10C);

        tick();  // ori $4,$0,0xBEEF
        expect_val("ori_imm", F_IMM, 32'h0000_BEEF);
        expect_val("ori_src", F_ALU_SRC, 32'd1);
        expect_val("ori_alu", F_ALU_OP, 32'(ALU_OR));
        expect_val("ori_dest", F_DEST, 32'd4);
        fetch(32'h110, enc_i(OP_LUI, 5'd0, 5'd5, 16'h8001));

        tick();  // lui $5,0x8001
        wb(5'd7, 32'h77, 1'b1);
        expect_val("lui_imm", F_IMM, 32'h8001_0000);
        expect_val("lui_dest", F_DEST, 32'd5);
        fetch(32'h114, enc_i(OP_ADDIU, 5'd0, 5'd6, 16'hFFFC));

        tick();  // addiu $6,$0,-4
        wb(5'd0, 32'h0, 1'b0);
        expect_val("addiu_imm", F_IMM, 32'hFFFF_FFFC);
        expect_val("addiu_rw", F_REG_WR, 32'd1);
        fetch(32'h118, enc_i(OP_LW, 5'd7, 5'd8, 16'hFFF8));

        tick();  // lw $8,-8($7); rt is not a source, so EX match on $8 must not stall
        hz(5'd8, 1'b1, 5'd0, 1'b0);
        expect_val("lw_rt_unused", F_STALL, 32'd0);
        expect_val("lw_mem_rd", F_MEM_RD, 32'd1);
        expect_val("lw_rs", F_RS, 32'h77);
        expect_val("lw_imm", F_IMM, 32'hFFFF_FFF8);
        expect_val("lw_dest", F_DEST, 32'd8);
        fetch(32'h11C, enc_i(OP_SW, 5'd7, 5'd8, 16'h0004));

        tick();  // sw $8,4($7)
        hz(5'd0, 1'b0, 5'd0, 1'b0);
        expect_val("sw_mem_wr", F_MEM_WR, 32'd1);
        expect_val("sw_rw", F_REG_WR, 32'd0);
        fetch(32'h40, enc_i(OP_BEQ, 5'd7, 5'd7, 16'h0003));

        tick();  // beq $7,$7,3 at 0x40
        expect_val("beq_sel", F_PC_SEL, 32'd1);
        expect_val("beq_baddr", F_BADDR, 32'h50);
        fetch(32'h44, enc_r(FN_ADDU, 5'd2, 5'd0, 5'd3, 5'd0));

        tick(); expect_nop("beq_flush");
        fetch(32'h50, enc_i(OP_BNE, 5'd7, 5'd7, 16'h0003));

        tick();  // bne with equal operands
        expect_val("bne_sel", F_PC_SEL, 32'd0);
        expect_val("bne_stall", F_STALL, 32'd0);
        fetch(32'h1000_0010, enc_j(OP_JAL, 26'h40));

        tick();  // jal
        wb(5'd31, 32'h2468, 1'b1);
        expect_val("jal_sel", F_PC_SEL, 32'd2);
        expect_val("jal_jaddr", F_JADDR, 32'h1000_0100);
        expect_val("jal_dest", F_DEST, 32'd31);
        expect_val("jal_link", F_LINK, 32'd1);
        expect_val("jal_npc", F_NPC, 32'h1000_0014);
        expect_val("jal_rw", F_REG_WR, 32'd1);
        fetch(32'h1000_0014, enc_r(FN_SLL, 5'd0, 5'd2, 5'd9, 5'd4));

        tick(); expect_nop("jal_flush");
        wb(5'd0, 32'h0, 1'b0);
        fetch(32'h200, enc_r(FN_JR, 5'd31, 5'd0, 5'd0, 5'd0));

        tick();  // jr $31 with MEM hazard on $31
        hz(5'd0, 1'b0, 5'd31, 1'b1);
        expect_val("jr_stall", F_STALL, 32'd1);
        expect_val("jr_stall_sel", F_PC_SEL, 32'd0);
        fetch(32'h204, enc_i(OP_ORI, 5'd0, 5'd4, 16'h0001));

        tick();  // hazard cleared
        hz(5'd0, 1'b0, 5'd0, 1'b0);
        expect_val("jr_sel", F_PC_SEL, 32'd2);
        expect_val("jr_jaddr", F_JADDR, 32'h2468);
        expect_val("jr_nostall", F_STALL, 32'd0);

        tick(); expect_nop("jr_flush");
        fetch(32'h2468, enc_r(FN_SLL, 5'd0, 5'd2, 5'd9, 5'd4));

        tick();  // sll $9,$2,4
        expect_val("sll_shamt", F_SHAMT, 32'd4);
        expect_val("sll_rt", F_RT, 32'h1234);
        expect_val("sll_alu", F_ALU_OP, 32'(ALU_SLL));
        expect_val("sll_dest", F_DEST, 32'd9);
        expect_val("sll_rw", F_REG_WR, 32'd1);
        fetch(32'h246C, enc_r(FN_OR, 5'd0, 5'd0, 5'd10, 5'd0));

        tick();  // or $10,$0,$0 with WB to $0 and EX "writing" $0
        wb(5'd0, 32'h5, 1'b1);
        hz(5'd0, 1'b1, 5'd0, 1'b0);
        expect_val("r0_bypass", F_RS, 32'h0);
        expect_val("r0_no_stall", F_STALL, 32'd0);
        expect_val("or_dest", F_DEST, 32'd10);
        fetch(32'h2470, enc_r(FN_ADDU, 5'd2, 5'd0, 5'd0, 5'd0));

        tick();  // addu $0,$2,$0
        wb(5'd0, 32'h0, 1'b0);
        hz(5'd0, 1'b0, 5'd0, 1'b0);
        expect_val("r0_ignored", F_RT, 32'h0);
        expect_val("dest0_rs", F_RS, 32'h1234);
        expect_val("dest0_rw", F_REG_WR, 32'd0);
        fetch(32'h2474, 32'hFC21_0001);

        tick();  // unsupported opcode
        expect_val("bad_rw", F_REG_WR, 32'd0);
        expect_val("bad_mem_rd", F_MEM_RD, 32'd0);
        expect_val("bad_mem_wr", F_MEM_WR, 32'd0);
        expect_val("bad_link", F_LINK, 32'd0);
        expect_val("bad_sel", F_PC_SEL, 32'd0);
        fetch(32'h500, enc_j(OP_J, 26'h100));

        tick();  // j redirect, reset asserted over this edge with a WB pending
        expect_val("j_sel", F_PC_SEL, 32'd2);
        expect_val("j_jaddr", F_JADDR, 32'h400);
        in_rst = 1'b0;
        wb(5'd9, 32'h99, 1'b1);
        fetch(32'h504, enc_r(FN_ADDU, 5'd2, 5'd0, 5'd3, 5'd0));

        tick(); expect_nop("rst_redirect");
        in_rst = 1'b1;
        wb(5'd0, 32'h0, 1'b0);
        fetch(32'h600, enc_r(FN_ADDU, 5'd2, 5'd9, 5'd3, 5'd0));

        tick();  // addu $3,$2,$9 after mid-run reset
        expect_val("rf_cleared", F_RS, 32'h0);
        expect_val("wb_blocked_in_rst", F_RT, 32'h0);

        tick();
        check("sb_drain", 32'(sb.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
